aes128_encrypt_iter: RTL



---
 rtl/aes128_encrypt_iter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption core: one cipher round per clock, round keys
// expanded on the fly, valid/ready handshakes on both the input and output sides.
module aes128_encrypt_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] ct_q, ct_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         out_valid_q, out_valid_d;

  logic [127:0] sub_bytes, shift_rows, mix_out, rk_next, round_out;
  logic [31:0]  rot_word, sub_word, w4, w5, w6, w7;

  // Byte n of the table sits at bits [2047-8n -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Round datapath; byte 4c+r of a 128-bit word is row r of column c.
  always_comb begin
    sub_bytes  = '0;
    shift_rows = '0;
    mix_out    = '0;
    for (int i = 0; i < 16; i++) begin
      sub_bytes[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_rows[127-8*(4*c+r) -: 8] = sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mix_out[127-32*c -: 32] = mix_col(shift_rows[127-32*c -: 32]);
    end

    rot_word  = {rk_q[23:0], rk_q[31:24]};
    sub_word  = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                 sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
    w4        = rk_q[127:96] ^ sub_word ^ {rcon(rnd_q), 24'h000000};
    w5        = rk_q[95:64] ^ w4;
    w6        = rk_q[63:32] ^ w5;
    w7        = rk_q[31:0]  ^ w6;
    rk_next   = {w4, w5, w6, w7};
    round_out = ((rnd_q == 4'd10) ? shift_rows : mix_out) ^ rk_next;
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    rk_d        = rk_q;
    rnd_d       = rnd_q;
    ct_d        = ct_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = plaintext ^ key;
          rk_d    = key;
          rnd_d   = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = round_out;
        rk_d    = rk_next;
        rnd_d   = rnd_q + 4'd1;
        if (rnd_q == 4'd10) begin
          ct_d        = round_out;
          out_valid_d = 1'b1;
          rnd_d       = 4'd0;
          fsm_d       = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rk_q        <= '0;
      rnd_q       <= 4'd0;
      ct_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rk_q        <= rk_d;
      rnd_q       <= rnd_d;
      ct_q        <= ct_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = (fsm_q == IDLE);
  assign busy       = (fsm_q == ROUND);
  assign out_valid  = out_valid_q;
  assign ciphertext = ct_q;

endmodule
